// File: rtl/rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter
//   Round-robin arbiter that shares one 8:1 single-bit mux among 8 requesters.
//   A single owner holds the channel at a time. Its tenure is capped at
//   MAX_HOLD consecutive cycles whenever another requester is waiting.
//
// Parameters
//   MAX_HOLD : max consecutive grant cycles per tenure (1..15)
//   CNT_W    : hold counter width, 2**CNT_W > MAX_HOLD
//
// Ports
//   clk       : clock, all state updates on rising edge
//   rst       : synchronous active-high reset
//   req[0:7]  : req[i]=1 -> requester i wants the channel
//   d[0:7]    : data bit of requester i (mux input i)
//   gnt[0:7]  : registered one-hot grant
//   gnt_valid : registered, high while a grant is active
//   s[2:0]    : registered mux select (index of current/last owner)
//   o         : d[s] gated by gnt_valid (combinational)
// -----------------------------------------------------------------------------
module rr_mux_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:7] req,
  input  logic [0:7] d,
  output logic [0:7] gnt,
  output logic       gnt_valid,
  output logic [2:0] s,
  output logic       o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  // Round-robin search: first set bit of r scanning start, start+1, ... with
  // 3-bit wrap. Result is {found, index}.
  function automatic logic [3:0] pick(input logic [0:7] r, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      idx = start + 3'(k);
      if (!res[3] && r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_t           state_r, state_n;
  logic [2:0]       s_r, s_n;
  logic [2:0]       ptr_r, ptr_n;
  logic [CNT_W-1:0] hold_r, hold_n;
  logic [0:7]       gnt_r, gnt_n;
  logic             gnt_valid_r;
  logic [0:7]       masked_s;
  logic [3:0]       win_s;

  // Next-state: arbitration, tenure limiting and grant decode.
  always_comb begin
    state_n  = state_r;
    s_n      = s_r;
    ptr_n    = ptr_r;
    hold_n   = hold_r;
    gnt_n    = 8'b0000_0000;
    win_s    = 4'b0000;
    masked_s = req;
    // The current owner is never a candidate when handing over.
    masked_s[s_r] = 1'b0;

    case (state_r)
      IDLE: begin
        win_s = pick(req, ptr_r);
        if (win_s[3]) begin
          state_n = GRANT;
          s_n     = win_s[2:0];
          ptr_n   = win_s[2:0] + 3'd1;
          hold_n  = {CNT_W{1'b0}};
        end else begin
          state_n = IDLE;
        end
      end
      GRANT: begin
        if (req[s_r] && (hold_r < HOLD_LAST)) begin
          hold_n = hold_r + CNT_W'(1);
        end else begin
          // Owner released or hit its limit: hand over if anyone else waits.
          win_s = pick(masked_s, s_r + 3'd1);
          if (win_s[3]) begin
            s_n    = win_s[2:0];
            ptr_n  = win_s[2:0] + 3'd1;
            hold_n = {CNT_W{1'b0}};
          end else if (req[s_r]) begin
            // Nobody else waiting: re-grant the same owner, fresh tenure.
            ptr_n  = s_r + 3'd1;
            hold_n = {CNT_W{1'b0}};
          end else begin
            state_n = IDLE;
            hold_n  = {CNT_W{1'b0}};
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (state_n == GRANT) begin
      gnt_n[s_n] = 1'b1;
    end else begin
      gnt_n = 8'b0000_0000;
    end
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      s_r         <= 3'd0;
      ptr_r       <= 3'd0;
      hold_r      <= {CNT_W{1'b0}};
      gnt_r       <= 8'b0000_0000;
      gnt_valid_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      s_r         <= s_n;
      ptr_r       <= ptr_n;
      hold_r      <= hold_n;
      gnt_r       <= gnt_n;
      gnt_valid_r <= (state_n == GRANT);
    end
  end

  assign gnt       = gnt_r;
  assign gnt_valid = gnt_valid_r;
  assign s         = s_r;
  assign o         = d[s_r] & gnt_valid_r;

endmodule
